uart_host_cmd_master: RTL and testbench
=======================================

// Module: uart_host_cmd_master
// PURPOSE
// - Host-side command initiator for the UART register/ALU system: encodes RF write, RF read, ALU-with-operands
//   and ALU-no-operand requests into UART command frames, and collects the response bytes.
// - Drives a byte-level UART TX serializer (valid/ready) whose line feeds the system RX_IN.
// - Takes bytes from a UART RX deserializer whose line is the system TX_OUT.
// - Used as the bench/host front end and as the master in loopback integration of the system top.
// PARAMETERS
// - DATA_WID      8      width of data / operand bytes (frames are byte-oriented; must be 8)
// - ADDR_WID      4      register-file address width; zero-extended to 8 bits on the wire
// - TIMEOUT_CYC   4096   CLK cycles allowed between response bytes before the transaction is abandoned
// PORTS
// - CLK          in   1            single clock
// - RST          in   1            asynchronous, active-high reset
// - cmd_valid    in   1            command request
// - cmd_ready    out  1            high in IDLE only; request accepted when cmd_valid && cmd_ready
// - cmd_type     in   2            0 RF_WR, 1 RF_RD, 2 ALU_OP, 3 ALU_NOP
// - cmd_addr     in   ADDR_WID     RF address (RF_WR/RF_RD)
// - cmd_data     in   DATA_WID     RF write data (RF_WR)
// - cmd_op_a     in   DATA_WID     operand A (ALU_OP)
// - cmd_op_b     in   DATA_WID     operand B (ALU_OP)
// - cmd_fun      in   4            ALU function (ALU_OP/ALU_NOP), zero-extended to 8 bits
// - tx_data      out  8            frame byte to serializer
// - tx_valid     out  1            tx_data valid; held with stable data until tx_ready
// - tx_ready     in   1            serializer accepts byte when tx_valid && tx_ready
// - rx_data      in   8            received response byte
// - rx_valid     in   1            one-cycle strobe per received byte
// - rsp_data     out  2*DATA_WID   response: {MSB byte, LSB byte}; RF_RD puts its byte in [7:0], [15:8] = 0
// - rsp_valid    out  1            one-cycle pulse when the response completes
// - rsp_timeout  out  1            one-cycle pulse when the response is abandoned
// - busy         out  1            ~cmd_ready
// BEHAVIOUR
// - Reset: state IDLE, cmd_ready=1, tx_valid=0, tx_data=0, rsp_data=0, rsp_valid=0, rsp_timeout=0, all counters 0.
// - Opcodes: RF_WR=0xAA, RF_RD=0xBB, ALU_OP=0xCC, ALU_NOP=0xDD.
// - Frames:
//   - RF_WR  = AA, addr, data            (3 bytes, 0 response bytes)
//   - RF_RD  = BB, addr                  (2 bytes, 1 response byte)
//   - ALU_OP = CC, A, B, fun             (4 bytes, 2 response bytes, LSB first)
//   - ALU_NOP= DD, fun                   (2 bytes, 2 response bytes, LSB first)
// - Command inputs are registered on acceptance; later changes on the cmd_* inputs have no effect.
// - FSM states:
//   - IDLE: on accept -> SEND with byte index 0.
//   - SEND: tx_valid=1 and tx_data = frame[idx]. On handshake, idx++. After the last byte:
//     - -> WAIT_RSP if the response length is > 0;
//     - else -> IDLE and pulse rsp_valid with rsp_data = 0.
//   - WAIT_RSP: each rx_valid stores its byte (LSB first) and clears the timeout counter. After the final byte:
//     - rsp_valid pulses the next cycle with the full rsp_data;
//     - -> IDLE.
// - Latency: tx_valid rises the cycle after acceptance. The first byte goes out in 1 cycle after acceptance
//   when tx_ready is held high. Back-to-back bytes go out with no bubble.
// - Timeout: the counter runs only in WAIT_RSP. When it reaches TIMEOUT_CYC-1 with no rx_valid:
//   - rsp_timeout pulses and rsp_data is left unchanged;
//   - -> IDLE.
//   - rx_valid on the expiry cycle takes precedence: the byte is accepted and no timeout occurs.
// - rx_valid outside WAIT_RSP (unsolicited or late byte) is ignored. It must not change rsp_data.
// - rsp_valid and rsp_timeout are mutually exclusive and never high in the same cycle.
// - The counter width is $clog2(TIMEOUT_CYC); there is no wrap because the counter is cleared on expiry.
// - RST asserted mid-frame or mid-response: immediate return to reset values; the partial frame is abandoned.
// STRUCTURE
// - Package uart_host_pkg holds:
//   - typedef enum logic[1:0] cmd_type_t {RF_WR, RF_RD, ALU_OP, ALU_NOP};
//   - the opcode localparams;
//   - the FSM state enum;
//   - functions frame_len(cmd_type_t) and rsp_len(cmd_type_t).
// - No sub-module. The byte mux and the timeout counter are local always_ff/always_comb blocks.
// TESTING
// - RF_WR addr=0x5 data=0x3C, tx_ready=1 -> bytes AA,05,3C on consecutive cycles; rsp_valid pulse;
//   rsp_data=0; cmd_ready back high.
// - RF_RD addr=0x2; rx byte 0x81 100 cycles later -> bytes BB,02; rsp_valid with rsp_data=0x0081.
// - ALU_OP A=0x0F B=0x11 fun=0x2; rx bytes FF then 00 -> bytes CC,0F,11,02; rsp_data=0x00FF.
// - tx_ready toggled 1/0 every cycle during ALU_NOP fun=0x3 -> tx_data stable while stalled;
//   exactly DD,03 sent once each.
// - RF_RD with no rx_valid -> rsp_timeout pulses exactly TIMEOUT_CYC cycles after the last tx handshake;
//   rsp_valid never asserts.
// - RST pulse during byte 2 of ALU_OP, then an unsolicited rx 0x55 -> tx_valid=0 immediately;
//   rsp_data stays 0; a new RF_WR frame is sent correctly.

Source files
------------

// File: rtl/uart_host_pkg.sv
// Shared types, opcodes and frame-length helpers for the UART host command master.
package uart_host_pkg;

   typedef enum logic [1:0] {RF_WR, RF_RD, ALU_OP, ALU_NOP} cmd_type_t;

   localparam logic [7:0] OP_RF_WR   = 8'hAA;
   localparam logic [7:0] OP_RF_RD   = 8'hBB;
   localparam logic [7:0] OP_ALU_OP  = 8'hCC;
   localparam logic [7:0] OP_ALU_NOP = 8'hDD;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_RSP} state_t;

   function automatic logic [2:0] frame_len(cmd_type_t t);
      logic [2:0] n;
      unique case (t)
         RF_WR:   n = 3'd3;
         RF_RD:   n = 3'd2;
         ALU_OP:  n = 3'd4;
         ALU_NOP: n = 3'd2;
         default: n = 3'd2;
      endcase
      return n;
   endfunction

   function automatic logic [1:0] rsp_len(cmd_type_t t);
      logic [1:0] n;
      unique case (t)
         RF_WR:   n = 2'd0;
         RF_RD:   n = 2'd1;
         ALU_OP:  n = 2'd2;
         ALU_NOP: n = 2'd2;
         default: n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/uart_host_cmd_master.sv
// Host-side UART command initiator: serializes RF/ALU command frames and
// collects LSB-first response bytes with an inter-byte timeout.
module uart_host_cmd_master
   import uart_host_pkg::*;
#(
   parameter int DATA_WID    = 8,
   parameter int ADDR_WID    = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_type,
   input  logic [ADDR_WID-1:0]   cmd_addr,
   input  logic [DATA_WID-1:0]   cmd_data,
   input  logic [DATA_WID-1:0]   cmd_op_a,
   input  logic [DATA_WID-1:0]   cmd_op_b,
   input  logic [3:0]            cmd_fun,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [2*DATA_WID-1:0] rsp_data,
   output logic                  rsp_valid,
   output logic                  rsp_timeout,
   output logic                  busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   state_t                state_q, state_d;
   cmd_type_t             type_q, type_d;
   logic [7:0]            addr_q, addr_d;
   logic [7:0]            data_q, data_d;
   logic [7:0]            opa_q, opa_d;
   logic [7:0]            opb_q, opb_d;
   logic [7:0]            fun_q, fun_d;
   logic [1:0]            idx_q, idx_d;
   logic                  rxi_q, rxi_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2*DATA_WID-1:0] rsp_q, rsp_d;
   logic                  rvld_q, rvld_d;
   logic                  rto_q, rto_d;
   logic [7:0]            fbyte;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         type_q  <= RF_WR;
         addr_q  <= '0;
         data_q  <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         fun_q   <= '0;
         idx_q   <= '0;
         rxi_q   <= 1'b0;
         cnt_q   <= '0;
         rsp_q   <= '0;
         rvld_q  <= 1'b0;
         rto_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         fun_q   <= fun_d;
         idx_q   <= idx_d;
         rxi_q   <= rxi_d;
         cnt_q   <= cnt_d;
         rsp_q   <= rsp_d;
         rvld_q  <= rvld_d;
         rto_q   <= rto_d;
      end
   end

   // Frame byte selected by the current byte index.
   always_comb begin
      fbyte = 8'h00;
      unique case (type_q)
         RF_WR:   fbyte = (idx_q == 2'd0) ? OP_RF_WR :
                          (idx_q == 2'd1) ? addr_q : data_q;
         RF_RD:   fbyte = (idx_q == 2'd0) ? OP_RF_RD : addr_q;
         ALU_OP:  fbyte = (idx_q == 2'd0) ? OP_ALU_OP :
                          (idx_q == 2'd1) ? opa_q :
                          (idx_q == 2'd2) ? opb_q : fun_q;
         ALU_NOP: fbyte = (idx_q == 2'd0) ? OP_ALU_NOP : fun_q;
         default: fbyte = 8'h00;
      endcase
   end

   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      addr_d  = addr_q;
      data_d  = data_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      fun_d   = fun_q;
      idx_d   = idx_q;
      rxi_d   = rxi_q;
      cnt_d   = cnt_q;
      rsp_d   = rsp_q;
      rvld_d  = 1'b0;
      rto_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               type_d  = cmd_type_t'(cmd_type);
               addr_d  = 8'(cmd_addr);
               data_d  = 8'(cmd_data);
               opa_d   = 8'(cmd_op_a);
               opb_d   = 8'(cmd_op_b);
               fun_d   = 8'(cmd_fun);
               idx_d   = 2'd0;
               rsp_d   = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (tx_ready) begin
               if ({1'b0, idx_q} == frame_len(type_q) - 3'd1) begin
                  if (rsp_len(type_q) != 2'd0) begin
                     state_d = S_WAIT_RSP;
                     cnt_d   = '0;
                     rxi_d   = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                     rvld_d  = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         S_WAIT_RSP: begin
            // A byte on the expiry cycle wins over the timeout.
            if (rx_valid) begin
               if (rxi_q) rsp_d[15:8] = rx_data;
               else       rsp_d[7:0]  = rx_data;
               cnt_d = '0;
               if ({1'b0, rxi_q} + 2'd1 == rsp_len(type_q)) begin
                  state_d = S_IDLE;
                  rvld_d  = 1'b1;
               end else begin
                  rxi_d = 1'b1;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               cnt_d   = '0;
               rto_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign cmd_ready   = (state_q == S_IDLE);
   assign busy        = ~cmd_ready;
   assign tx_valid    = (state_q == S_SEND);
   assign tx_data     = tx_valid ? fbyte : 8'h00;
   assign rsp_data    = rsp_q;
   assign rsp_valid   = rvld_q;
   assign rsp_timeout = rto_q;

endmodule

// File: tb/tb_uart_host_cmd_master.sv
// Directed scoreboard bench for uart_host_cmd_master.
module tb_uart_host_cmd_master;
   import uart_host_pkg::*;

   localparam int T = 256;

   logic        CLK = 1'b0;
   logic        RST;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_type;
   logic [3:0]  cmd_addr;
   logic [7:0]  cmd_data, cmd_op_a, cmd_op_b;
   logic [3:0]  cmd_fun;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [15:0] rsp_data;
   logic        rsp_valid, rsp_timeout, busy;

   uart_host_cmd_master #(.DATA_WID(8), .ADDR_WID(4), .TIMEOUT_CYC(T)) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_op_a(cmd_op_a),
      .cmd_op_b(cmd_op_b), .cmd_fun(cmd_fun),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout),
      .busy(busy)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int fails = 0;
   int cyc   = 0;
   int acc_edge = 0;
   int to_edge  = 0;
   int n_rsp = 0;
   int n_to  = 0;
   logic [7:0]  tx_exp[$];
   logic [15:0] rsp_exp[$];
   int          hs_edges[$];
   logic        stall_q = 1'b0;
   logic [7:0]  stall_byte = 8'h00;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor samples on the falling edge; inputs change just after rising edges.
   always @(negedge CLK) begin
      if (RST) begin
         stall_q = 1'b0;
      end else begin
         if (cmd_valid && cmd_ready) acc_edge = cyc + 1;
         if (tx_valid && stall_q) chk("tx_hold", {24'h0, tx_data}, {24'h0, stall_byte});
         stall_q    = tx_valid && !tx_ready;
         stall_byte = tx_data;
         if (tx_valid && tx_ready) begin
            hs_edges.push_back(cyc + 1);
            if (tx_exp.size() == 0) chk("tx_extra", {24'h0, tx_data}, 32'hFFFF_FFFF);
            else chk("tx_byte", {24'h0, tx_data}, {24'h0, tx_exp.pop_front()});
         end
         if (rsp_valid || rsp_timeout)
            chk("rsp_excl", {31'h0, rsp_valid & rsp_timeout}, 32'h0);
         if (rsp_valid) begin
            n_rsp++;
            if (rsp_exp.size() == 0) chk("rsp_extra", {16'h0, rsp_data}, 32'hFFFF_FFFF);
            else chk("rsp_data", {16'h0, rsp_data}, {16'h0, rsp_exp.pop_front()});
         end
         if (rsp_timeout) begin
            n_to++;
            to_edge = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
      int k;
      k = 0;
      while (!cmd_ready && k < 50) begin
         tick();
         k++;
      end
      chk("cmd_ready_wait", {31'h0, cmd_ready}, 32'h1);
      cmd_type = t; cmd_addr = a; cmd_data = d;
      cmd_op_a = oa; cmd_op_b = ob; cmd_fun = f;
      cmd_valid = 1'b1;
      case (t)
         2'd0: begin tx_exp.push_back(8'hAA); tx_exp.push_back({4'h0, a}); tx_exp.push_back(d); end
         2'd1: begin tx_exp.push_back(8'hBB); tx_exp.push_back({4'h0, a}); end
         2'd2: begin
            tx_exp.push_back(8'hCC); tx_exp.push_back(oa);
            tx_exp.push_back(ob); tx_exp.push_back({4'h0, f});
         end
         default: begin tx_exp.push_back(8'hDD); tx_exp.push_back({4'h0, f}); end
      endcase
      tick();
      cmd_valid = 1'b0;
      cmd_type = 2'($urandom); cmd_addr = 4'($urandom); cmd_data = 8'($urandom);
      cmd_op_a = 8'($urandom); cmd_op_b = 8'($urandom); cmd_fun = 4'($urandom);
   endtask

   task automatic wait_tx_empty(input string tag);
      int k;
      k = 0;
      while (tx_exp.size() != 0 && k < 60) begin
         tick();
         k++;
      end
      chk(tag, tx_exp.size(), 0);
   endtask

   task automatic wait_rsp(input int n0, input int budget, input string tag);
      int k;
      k = 0;
      while (n_rsp + n_to == n0 && k < budget) begin
         tick();
         k++;
      end
      chk(tag, n_rsp + n_to - n0, 1);
   endtask

   task automatic rx_pulse(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      int n0;
      int last;
      RST = 1'b1; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_addr = 4'h0;
      cmd_data = 8'h0; cmd_op_a = 8'h0; cmd_op_b = 8'h0; cmd_fun = 4'h0;
      tx_ready = 1'b0; rx_data = 8'h0; rx_valid = 1'b0;
      repeat (3) tick();
      chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
      chk("rst_rsp_data", {16'h0, rsp_data}, 32'h0);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rsp_timeout", {31'h0, rsp_timeout}, 32'h0);
      RST = 1'b0;
      tick();

      // RF write: three back-to-back bytes, immediate empty response
      tx_ready = 1'b1;
      hs_edges.delete();
      n0 = n_rsp + n_to;
      rsp_exp.push_back(16'h0000);
      do_cmd(2'd0, 4'h5, 8'h3C, 8'h0, 8'h0, 4'h0);
      wait_rsp(n0, 40, "wr_done");
      chk("wr_first_lat", hs_edges[0] - acc_edge, 1);
      chk("wr_b2b", hs_edges[2] - hs_edges[0], 2);
      chk("wr_nbytes", hs_edges.size(), 3);
      tick();
      chk("wr_ready", {31'h0, cmd_ready}, 32'h1);

      // RF read: response byte after 100 cycles
      n0 = n_rsp + n_to;
      rsp_exp.push_back(16'h0081);
      do_cmd(2'd1, 4'h2, 8'h0, 8'h0, 8'h0, 4'h0);
      wait_tx_empty("rd_tx");
      repeat (100) tick();
      chk("rd_busy", {31'h0, busy}, 32'h1);
      rx_pulse(8'h81);
      wait_rsp(n0, 10, "rd_done");

      // ALU with operands: LSB first
      n0 = n_rsp + n_to;
      rsp_exp.push_back(16'h00FF);
      do_cmd(2'd2, 4'h0, 8'h0, 8'h0F, 8'h11, 4'h2);
      wait_tx_empty("alu_tx");
      repeat (5) tick();
      rx_pulse(8'hFF);
      repeat (3) tick();
      rx_pulse(8'h00);
      wait_rsp(n0, 10, "alu_done");
      rx_pulse(8'h77);
      tick();
      chk("idle_rx_ignored", {16'h0, rsp_data}, 32'h00FF);

      // ALU no-operand with tx_ready toggling
      n0 = n_rsp + n_to;
      hs_edges.delete();
      tx_ready = 1'b0;
      rsp_exp.push_back(16'h1234);
      do_cmd(2'd3, 4'h0, 8'h0, 8'h0, 8'h0, 4'h3);
      for (int k = 0; k < 40 && tx_exp.size() != 0; k++) begin
         tx_ready = ~tx_ready;
         tick();
      end
      tx_ready = 1'b1;
      tick();
      chk("nop_nbytes", hs_edges.size(), 2);
      rx_pulse(8'h34);
      rx_pulse(8'h12);
      wait_rsp(n0, 10, "nop_done");

      // RF read without response: timeout
      n0 = n_to;
      hs_edges.delete();
      do_cmd(2'd1, 4'h7, 8'h0, 8'h0, 8'h0, 4'h0);
      wait_tx_empty("to_tx");
      last = hs_edges[$];
      wait_rsp(n_rsp + n_to, T + 50, "to_done");
      chk("to_count", n_to - n0, 1);
      chk("to_delay", to_edge - last, T);
      chk("to_rsp_data", {16'h0, rsp_data}, 32'h0);
      tick();
      chk("to_ready", {31'h0, cmd_ready}, 32'h1);

      // Byte arriving on the expiry cycle wins
      n0 = n_to;
      hs_edges.delete();
      rsp_exp.push_back(16'h0042);
      do_cmd(2'd1, 4'h3, 8'h0, 8'h0, 8'h0, 4'h0);
      wait_tx_empty("exp_tx");
      last = hs_edges[$];
      while (cyc < last + T - 1) tick();
      rx_pulse(8'h42);
      tick();
      chk("exp_no_timeout", n_to - n0, 0);
      chk("exp_rsp", {16'h0, rsp_data}, 32'h0042);

      // Reset during byte 2 of an ALU frame
      do_cmd(2'd2, 4'h0, 8'h0, 8'h21, 8'h43, 4'h1);
      tick();
      chk("mid_tx_valid", {31'h0, tx_valid}, 32'h1);
      RST = 1'b1;
      #1;
      chk("rst_mid_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("rst_mid_tx_data", {24'h0, tx_data}, 32'h0);
      chk("rst_mid_ready", {31'h0, cmd_ready}, 32'h1);
      chk("rst_mid_rsp", {16'h0, rsp_data}, 32'h0);
      tx_exp.delete();
      tick();
      RST = 1'b0;
      tick();
      rx_pulse(8'h55);
      tick();
      chk("rst_unsol_rx", {16'h0, rsp_data}, 32'h0);
      n0 = n_rsp + n_to;
      hs_edges.delete();
      rsp_exp.push_back(16'h0000);
      do_cmd(2'd0, 4'h9, 8'hA5, 8'h0, 8'h0, 4'h0);
      wait_rsp(n0, 40, "post_rst_done");
      chk("post_rst_nbytes", hs_edges.size(), 3);
      chk("post_rst_txq", tx_exp.size(), 0);
      chk("rsp_q_empty", rsp_exp.size(), 0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
